// File: rtl/mem_port_arbiter_pkg.sv
// arb_types: FSM state type and default widths shared by mem_port_arbiter and rr_grant
package arb_types;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mem_port_arbiter_rr_grant.sv
// rr_grant: combinational one-hot grant of the first requester found at or after ptr_i
module rr_grant
  import arb_types::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);
  int j;
  // walk from lowest to highest priority so the winning requester is written last
  always_comb begin
    j = 0;
    idx_o = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_CH;
      if (req_i[j]) idx_o = j[IDX_W-1:0];
    end
    gnt_o = '0;
    if (|req_i) gnt_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: NUM_CH requesters share one memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module mem_port_arbiter
  import arb_types::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_mbe,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_mbe,
  input  logic                       mem_resp,
  input  logic [DATA_W-1:0]          mem_rdata
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MBE_W = DATA_W / 8;
  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, gidx, ptr;
  logic [NUM_CH-1:0] req, gnt;
  logic rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MBE_W-1:0] mbe_q, mbe_d;
  assign req = ch_read | ch_write;
  rr_grant #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_grant (
    .req_i(req),
    .ptr_i(ptr),
    .gnt_o(gnt),
    .idx_o(gidx)
  );
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign ptr_d = (gidx == IDX_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
  // move priority to the channel after each new grant
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else if (state_q == IDLE && |req) ptr_q <= ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif
  // latch the winner's command in IDLE, hold it until the memory answers in BUSY
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rd_d = rd_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    mbe_d = mbe_q;
    if (state_q == IDLE && |req) begin
      state_d = BUSY;
      grant_d = gidx;
      rd_d = |(gnt & ch_read & ~ch_write);
      wr_d = |(gnt & ch_write);
      addr_d = ch_addr[int'(gidx)*ADDR_W +: ADDR_W];
      wdata_d = ch_wdata[int'(gidx)*DATA_W +: DATA_W];
      mbe_d = ch_mbe[int'(gidx)*MBE_W +: MBE_W];
    end else if (state_q == BUSY && mem_resp) begin
      state_d = IDLE;
      rd_d = 1'b0;
      wr_d = 1'b0;
    end
  end
  // state and downstream command registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      mbe_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      mbe_q <= mbe_d;
    end
  // completion goes straight back to the granted channel in the response cycle
  always_comb begin
    ch_resp = '0;
    if (state_q == BUSY && mem_resp) ch_resp[grant_q] = 1'b1;
  end
  assign ch_rdata = mem_rdata;
  assign mem_read = rd_q;
  assign mem_write = wr_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_mbe = mbe_q;
endmodule
